sa9226_scan: RTL and testbench

Periodic register scanner upstream of `sa9226_ctrl`. It issues one-byte reads for a contiguous range of SA9226 register addresses through the controller's valid/ready request port, and stores each returned byte in a local shadow register file. It retries on NACK or timeout and exposes the shadow values, per-register valid flags and an error counter to host logic. This lets host logic read SA9226 registers without per-access I2C latency.

---
 rtl/sa9226_scan.sv | 140 ++++++++++++++
 tb/tb_sa9226_scan.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa9226_scan.sv
// sa9226_scan: periodic SA9226 register scanner feeding a local shadow file.
// Issues one-byte reads via sa9226_ctrl, retries on NACK/timeout.
module sa9226_scan #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int NUM_REGS = 8,
  parameter int PERIOD = 100000,
  parameter int TIMEOUT = 65535,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        scan_now,
  output logic        ctl_valid,
  input  logic        ctl_ready,
  output logic        ctl_direct,
  output logic [7:0]  ctl_addr,
  output logic [7:0]  ctl_din,
  input  logic        ctl_dout_vld,
  input  logic [7:0]  ctl_dout,
  input  logic        ctl_dout_err,
  input  logic [3:0]  rd_idx,
  output logic [7:0]  rd_data,
  output logic [15:0] vld_mask,
  output logic        busy,
  output logic        scan_done,
  output logic [7:0]  err_cnt
);

  localparam int PW =
    ($clog2(PERIOD) > 17) ? $clog2(PERIOD) : 17;
  localparam logic [PW-1:0] P_LOAD = PW'(PERIOD - 1);
  localparam logic [3:0] LAST = 4'(NUM_REGS - 1);
  localparam logic [4:0] NREG = 5'(NUM_REGS);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [2:0] RMAX = 3'(MAX_RETRY);
  localparam logic [15:0] VM =
    16'((17'd1 << NUM_REGS) - 17'd1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_RESP, NEXT
  } state_t;

  state_t state, state_nx;

  logic [3:0]    idx;
  logic [2:0]    retry;
  logic [15:0]   tmr;
  logic [PW-1:0] period_cnt;
  logic          by_period;
  logic [7:0]    shadow [16];
  logic [15:0]   vld_q;

  logic trig, start, good, fail, last, can_retry;

  assign trig = enable && state == IDLE
             && period_cnt == '0;
  assign start = state == IDLE && (trig || scan_now);
  assign good = state == WAIT_RESP
             && ctl_dout_vld && !ctl_dout_err;
  assign fail = state == WAIT_RESP
             && (ctl_dout_vld ? ctl_dout_err
                              : tmr == TMO_LAST);
  assign can_retry = retry < RMAX;
  // a period-started scan is cut short once enable drops
  assign last = idx == LAST || (!enable && by_period);

  assign ctl_valid = state == ISSUE;
  assign ctl_direct = 1'b0;
  assign ctl_din = 8'h00;
  assign ctl_addr = BASE_ADDR + {4'd0, idx};
  assign busy = state != IDLE;
  assign vld_mask = vld_q & VM;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start) state_nx = ISSUE;
      ISSUE:
        if (ctl_ready) state_nx = WAIT_RESP;
      WAIT_RESP:
        if (good) state_nx = NEXT;
        else if (fail)
          state_nx = can_retry ? ISSUE : NEXT;
      NEXT:
        state_nx = last ? IDLE : ISSUE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      retry <= '0;
      tmr <= '0;
      period_cnt <= P_LOAD;
      by_period <= 1'b0;
      vld_q <= '0;
      err_cnt <= '0;
      scan_done <= 1'b0;
      rd_data <= '0;
      for (int i = 0; i < 16; i++) shadow[i] <= '0;
    end else begin
      scan_done <= state == NEXT && last;
      rd_data <= ({1'b0, rd_idx} < NREG)
               ? shadow[rd_idx] : 8'h00;
      if (enable && state == IDLE)
        period_cnt <= trig ? P_LOAD
                           : period_cnt - PW'(1);
      if (start) begin
        idx <= '0;
        retry <= '0;
        by_period <= trig;
      end
      if (state == ISSUE && ctl_ready) tmr <= '0;
      if (state == WAIT_RESP) tmr <= tmr + 16'd1;
      if (good) begin
        shadow[idx] <= ctl_dout;
        vld_q[idx] <= 1'b1;
      end
      if (fail) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (can_retry) retry <= retry + 3'd1;
        else           vld_q[idx] <= 1'b0;
      end
      if (state == NEXT) begin
        retry <= '0;
        if (!last) idx <= idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_sa9226_scan.sv
// tb_sa9226_scan: directed bench with a controller responder and
// a per-scan outcome model of the scanner.
module tb_sa9226_scan;
  localparam int NR = 4;
  localparam int PER = 200;
  localparam int TMO = 50;
  localparam int MR = 3;
  localparam logic [7:0] BASE = 8'h10;

  logic clk = 1'b0;
  logic rst, enable, scan_now;
  logic ctl_valid, ctl_ready, ctl_direct;
  logic [7:0] ctl_addr, ctl_din, ctl_dout;
  logic ctl_dout_vld, ctl_dout_err;
  logic [3:0] rd_idx;
  logic [7:0] rd_data, err_cnt;
  logic [15:0] vld_mask;
  logic busy, scan_done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sa9226_scan #(
    .BASE_ADDR(BASE), .NUM_REGS(NR), .PERIOD(PER),
    .TIMEOUT(TMO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .scan_now(scan_now), .ctl_valid(ctl_valid),
    .ctl_ready(ctl_ready), .ctl_direct(ctl_direct),
    .ctl_addr(ctl_addr), .ctl_din(ctl_din),
    .ctl_dout_vld(ctl_dout_vld), .ctl_dout(ctl_dout),
    .ctl_dout_err(ctl_dout_err), .rd_idx(rd_idx),
    .rd_data(rd_data), .vld_mask(vld_mask),
    .busy(busy), .scan_done(scan_done),
    .err_cnt(err_cnt)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // responder policy and state
  int nack_pol [NR];
  int noresp_pol [NR];
  int nack_left [NR];
  bit pend = 0;
  int cd = 0;
  int pend_i = 0;
  bit live = 0;

  // outcome model
  logic [7:0] m_sh [NR];
  logic [15:0] m_vld = '0;
  int m_err = 0;
  logic [7:0] exp_q [$];

  // observation
  int cyc = 0;
  int hs_cnt [NR];
  int hs_last [NR];
  int resp_cyc = 0;
  int resp_i = 0;
  bit resp_chk = 0;
  int idle_cnt = 0;
  bit period_mode = 0;
  int nscan = 0;
  int ndone = 0;

  function automatic void build_scan();
    logic [7:0] a;
    int fails;
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      a = BASE + 8'(i);
      if (noresp_pol[i] != 0 || nack_pol[i] > MR)
        fails = MR + 1;
      else
        fails = nack_pol[i];
      for (int k = 0; k < fails; k++) exp_q.push_back(a);
      if (fails <= MR) begin
        exp_q.push_back(a);
        m_sh[i] = a ^ 8'hA5;
        m_vld[i] = 1'b1;
      end else begin
        m_vld[i] = 1'b0;
      end
      m_err = (m_err + fails > 255) ? 255 : m_err + fails;
      nack_left[i] = nack_pol[i];
      hs_cnt[i] = 0;
    end
  endfunction

  // responder + compare process
  initial begin : mon
    logic pv, pr, pbusy, pdone;
    logic [7:0] pa;
    int i;
    pv = 0; pr = 0; pbusy = 0; pdone = 0; pa = '0;
    ctl_dout_vld = 0; ctl_dout_err = 0; ctl_dout = '0;
    forever begin
      @(negedge clk);
      cyc++;
      ctl_dout_vld = 0;
      ctl_dout_err = 0;
      if (resp_chk) begin
        chk("vld_upd", 32'(vld_mask[resp_i]), 1);
        resp_chk = 0;
      end
      if (pend) begin
        cd--;
        if (cd == 0) begin
          pend = 0;
          ctl_dout_vld = 1;
          ctl_dout = (BASE + 8'(pend_i)) ^ 8'hA5;
          if (nack_left[pend_i] > 0) begin
            ctl_dout_err = 1;
            nack_left[pend_i]--;
          end
          if (!ctl_dout_err && live) begin
            resp_chk = 1;
            resp_i = pend_i;
            resp_cyc = cyc;
          end
        end
      end
      if (busy && !pbusy) begin
        build_scan();
        if (period_mode) chk("period", idle_cnt, PER);
        idle_cnt = 0;
        nscan++;
      end
      if (!busy && enable) idle_cnt++;
      if (pv && !pr) begin
        chk("valid_hold", 32'(ctl_valid), 1);
        chk("addr_hold", 32'(ctl_addr), 32'(pa));
      end
      if (pv && pr) chk("valid_drop", 32'(ctl_valid), 0);
      if (ctl_valid && ctl_ready) begin
        chk("direct", 32'(ctl_direct), 0);
        chk("din", 32'(ctl_din), 0);
        if (exp_q.size() == 0) chk("extra_req", 1, 0);
        else chk("req_addr", 32'(ctl_addr),
                 32'(exp_q.pop_front()));
        i = int'(ctl_addr - BASE);
        if (i >= 0 && i < NR) begin
          hs_cnt[i]++;
          if (noresp_pol[i] != 0 && hs_cnt[i] > 1)
            chk("tmo_gap", cyc - hs_last[i], TMO + 1);
          hs_last[i] = cyc;
          live = 1;
          if (noresp_pol[i] == 0) begin
            pend = 1;
            cd = 20;
            pend_i = i;
          end
        end
      end
      if (pdone) chk("done_pulse", 32'(scan_done), 0);
      if (scan_done) begin
        ndone++;
        chk("done_idle", 32'(busy), 0);
        chk("done_after_busy", 32'(pbusy), 1);
        chk("done_err", 32'(err_cnt), m_err);
        chk("done_vld", 32'(vld_mask), 32'(m_vld));
        chk("done_reqs", exp_q.size(), 0);
        if (m_vld[NR-1]) chk("done_lat", cyc - resp_cyc, 2);
      end
      pv = ctl_valid; pr = ctl_ready; pa = ctl_addr;
      pbusy = busy; pdone = scan_done;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_now();
    scan_now = 1;
    tick();
    scan_now = 0;
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!scan_done && k < lim);
    if (!scan_done) chk("done_timeout", 0, 1);
    tick();
  endtask

  task automatic rd(input int i, input logic [7:0] e);
    rd_idx = 4'(i);
    tick();
    chk($sformatf("rd%0d", i), 32'(rd_data), 32'(e));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k, n0, d0;
    for (int i = 0; i < NR; i++) begin
      nack_pol[i] = 0; noresp_pol[i] = 0;
      nack_left[i] = 0; m_sh[i] = '0;
      hs_cnt[i] = 0; hs_last[i] = 0;
    end
    rst = 1; enable = 0; scan_now = 0;
    ctl_ready = 1; rd_idx = '0;
    tick(3);
    chk("rst_valid", 32'(ctl_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(scan_done), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_rd", 32'(rd_data), 0);
    chk("rst_vld", 32'(vld_mask), 0);
    rst = 0;
    tick(2);

    // clean scan
    pulse_now();
    chk("start_lat", 32'(ctl_valid), 1);
    chk("start_addr", 32'(ctl_addr), 32'h10);
    wait_done(2000);
    rd(0, 8'hB5); rd(1, 8'hB4);
    rd(2, 8'hB7); rd(3, 8'hB6);
    rd(4, 8'h00); rd(15, 8'h00);
    chk("a_vld", 32'(vld_mask), 32'h000F);
    chk("a_err", 32'(err_cnt), 0);
    chk("a_done", ndone, 1);
    for (int i = 0; i < NR; i++)
      chk($sformatf("a_hs%0d", i), hs_cnt[i], 1);

    // NACK 0x11 twice
    nack_pol[1] = 2;
    pulse_now();
    wait_done(3000);
    chk("b_hs11", hs_cnt[1], 3);
    chk("b_err", 32'(err_cnt), 2);
    chk("b_vld1", 32'(vld_mask[1]), 1);
    rd(1, 8'hB4);

    // no response from 0x12
    nack_pol[1] = 0;
    noresp_pol[2] = 1;
    pulse_now();
    wait_done(4000);
    chk("c_hs12", hs_cnt[2], 4);
    chk("c_hs13", hs_cnt[3], 1);
    chk("c_err", 32'(err_cnt), 6);
    chk("c_vld", 32'(vld_mask), 32'h000B);
    rd(2, 8'hB7);

    // periodic scans with a stalled controller
    noresp_pol[2] = 0;
    ctl_ready = 0;
    period_mode = 1;
    n0 = nscan; d0 = ndone;
    idle_cnt = 0;
    enable = 1;
    k = 0;
    while (!ctl_valid && k < 400) begin tick(); k++; end
    chk("p_first_valid", 32'(ctl_valid), 1);
    tick(30);
    chk("p_stall_addr", 32'(ctl_addr), 32'h10);
    ctl_ready = 1;
    tick(5);
    pulse_now();
    wait_done(3000);
    wait_done(3000);
    wait_done(3000);
    enable = 0;
    period_mode = 0;
    chk("p_scans", nscan - n0, 3);
    chk("p_dones", ndone - d0, 3);
    chk("p_vld", 32'(vld_mask), 32'h000F);
    chk("p_err", 32'(err_cnt), 6);

    // reset during WAIT_RESP of register 2
    pulse_now();
    k = 0;
    while (hs_cnt[2] == 0 && k < 500) begin tick(); k++; end
    chk("r_reached", hs_cnt[2], 1);
    tick(5);
    rst = 1;
    live = 0;
    tick();
    chk("r_busy", 32'(busy), 0);
    chk("r_valid", 32'(ctl_valid), 0);
    chk("r_vld", 32'(vld_mask), 0);
    chk("r_rd", 32'(rd_data), 0);
    chk("r_err", 32'(err_cnt), 0);
    rst = 0;
    m_err = 0; m_vld = '0;
    exp_q.delete();
    for (int i = 0; i < NR; i++) m_sh[i] = '0;
    tick(30);
    chk("r_late_busy", 32'(busy), 0);
    chk("r_late_vld", 32'(vld_mask), 0);
    rd(2, 8'h00);

    // err_cnt saturation: 16 failures per scan
    for (int i = 0; i < NR; i++) nack_pol[i] = 7;
    for (int s = 0; s < 15; s++) begin
      pulse_now();
      wait_done(2000);
    end
    chk("s_err240", 32'(err_cnt), 240);
    pulse_now();
    wait_done(2000);
    chk("s_err_sat", 32'(err_cnt), 32'hFF);
    chk("s_vld", 32'(vld_mask), 0);
    rd(0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
